// File: rtl/vector_dot_stream_ctrl_if.sv
// rtl/vector_dot_stream_ctrl_if.sv - job request, beat stream and result handshakes of the dot-product controller
interface vector_dot_stream_ctrl_if #(
  parameter int element_width = 32,
  parameter int no_of_units   = 8,
  parameter int acc_width     = 2*element_width+16
);
  logic                                 start;
  logic                                 abort;
  logic [31:0]                          total;
  logic                                 in_valid;
  logic                                 in_ready;
  logic [element_width*no_of_units-1:0] vec_a;
  logic [element_width*no_of_units-1:0] vec_b;
  logic [acc_width-1:0]                 result;
  logic                                 result_valid;
  logic                                 result_ready;
  logic                                 busy;

  modport master (
    output start, abort, total, in_valid, vec_a, vec_b, result_ready,
    input  in_ready, result, result_valid, busy
  );

  modport slave (
    input  start, abort, total, in_valid, vec_a, vec_b, result_ready,
    output in_ready, result, result_valid, busy
  );
endinterface

// File: rtl/vector_dot_stream_ctrl.sv
// rtl/vector_dot_stream_ctrl.sv - streaming signed dot product with beat flow control, last-beat masking and abort
module vector_dot_stream_ctrl #(
  parameter int element_width = 32,
  parameter int no_of_units   = 8,
  parameter int acc_width     = 2*element_width+16
) (
  input logic                     clk,
  input logic                     reset,
  vector_dot_stream_ctrl_if.slave bus
);
  localparam int PROD_W = 2*element_width;
  localparam int LANE_W = $clog2(no_of_units);
  localparam int CNT_W  = LANE_W + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DRAIN, ST_DONE} state_t;

  state_t                      r_state;
  logic [31:0]                 r_beats;
  logic [31:0]                 r_beat_cnt;
  logic [CNT_W-1:0]            r_last_lanes;
  logic                        r_in_ready;
  logic                        r_result_valid;
  logic                        r_busy;
  logic signed [acc_width-1:0] r_acc;
  logic signed [acc_width-1:0] r_result;

  logic signed [PROD_W-1:0]    r_prod [no_of_units];
  logic                        r_s1_valid;
  logic                        r_s1_last;
  logic signed [acc_width-1:0] r_sum;
  logic                        r_s2_valid;
  logic                        r_s2_last;

  logic                        w_abort;
  logic                        w_fire;
  logic                        w_last_beat;
  logic                        w_acc_en;
  logic [32:0]                 w_beats_calc;
  logic [LANE_W-1:0]           w_rem;
  logic signed [acc_width-1:0] w_tree;
  logic signed [acc_width-1:0] w_acc_next;
  logic signed [PROD_W-1:0]    w_lane_prod [no_of_units];

  assign w_abort      = bus.abort && (r_state != ST_IDLE);
  assign w_fire       = (r_state == ST_LOAD) && bus.in_valid && !bus.abort;
  assign w_last_beat  = (r_beat_cnt == r_beats - 32'd1);
  assign w_beats_calc = ({1'b0, bus.total} + 33'(no_of_units - 1)) >> LANE_W;
  assign w_rem        = bus.total[LANE_W-1:0];
  assign w_acc_en     = r_s2_valid && !w_abort;
  assign w_acc_next   = r_acc + r_sum;

  assign bus.in_ready     = r_in_ready;
  assign bus.result_valid = r_result_valid;
  assign bus.result       = r_result;
  assign bus.busy         = r_busy;

  // Lanes are sign-extended to the full product width so the truncated product is exact.
  always_comb begin
    for (int i = 0; i < no_of_units; i++) begin
      w_lane_prod[i] =
        $signed({{element_width{bus.vec_a[(i+1)*element_width-1]}}, bus.vec_a[i*element_width +: element_width]}) *
        $signed({{element_width{bus.vec_b[(i+1)*element_width-1]}}, bus.vec_b[i*element_width +: element_width]});
    end
  end

  always_comb begin
    w_tree = '0;
    for (int i = 0; i < no_of_units; i++) begin
      w_tree = w_tree + $signed({{(acc_width-PROD_W){r_prod[i][PROD_W-1]}}, r_prod[i]});
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < no_of_units; i++) r_prod[i] <= '0;
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_sum      <= '0;
      r_s2_valid <= 1'b0;
      r_s2_last  <= 1'b0;
    end else begin
      r_s1_valid <= w_fire;
      r_s1_last  <= w_fire && w_last_beat;
      r_s2_valid <= r_s1_valid && !w_abort;
      r_s2_last  <= r_s1_last;
      r_sum      <= w_tree;
      // Lanes beyond the job length on the final beat carry don't-care data.
      for (int i = 0; i < no_of_units; i++) begin
        if (w_fire) begin
          r_prod[i] <= (w_last_beat && (CNT_W'(i) >= r_last_lanes)) ? '0 : w_lane_prod[i];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_beats        <= '0;
      r_beat_cnt     <= '0;
      r_last_lanes   <= '0;
      r_in_ready     <= 1'b0;
      r_result_valid <= 1'b0;
      r_busy         <= 1'b0;
      r_acc          <= '0;
      r_result       <= '0;
    end else begin
      if (w_acc_en) r_acc <= w_acc_next;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_beats      <= w_beats_calc[31:0];
            r_beat_cnt   <= '0;
            r_last_lanes <= (w_rem == '0) ? CNT_W'(no_of_units) : {1'b0, w_rem};
            r_acc        <= '0;
            r_busy       <= 1'b1;
            if (w_beats_calc == '0) begin
              r_state        <= ST_DONE;
              r_result       <= '0;
              r_result_valid <= 1'b1;
            end else begin
              r_state    <= ST_LOAD;
              r_in_ready <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (w_abort) begin
            r_state    <= ST_IDLE;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
          end else if (w_fire) begin
            r_beat_cnt <= r_beat_cnt + 32'd1;
            if (w_last_beat) begin
              r_state    <= ST_DRAIN;
              r_in_ready <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          if (w_abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (r_s2_valid && r_s2_last) begin
            r_state        <= ST_DONE;
            r_result       <= w_acc_next;
            r_result_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (w_abort || bus.result_ready) begin
            r_state        <= ST_IDLE;
            r_result_valid <= 1'b0;
            r_result       <= '0;
            r_busy         <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule
